// File: rtl/vdma_stream_arb.sv
// Frame-granular round-robin arbiter merging two AXI-Stream video sources onto one output.
// Grant changes only at frame boundaries; stale non-SOF beats are flushed while arbitrating.
module vdma_stream_arb #(
    parameter int DATA_W = 64,
    parameter int ROW_W  = 16
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_aresetn,
    input  logic              cfg_en,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic [ROW_W-1:0]  cfg_gap,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic              s0_axis_tvalid,
    input  logic              s0_axis_tuser,
    input  logic              s0_axis_tlast,
    output logic              s0_axis_tready,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic              s1_axis_tvalid,
    input  logic              s1_axis_tuser,
    input  logic              s1_axis_tlast,
    output logic              s1_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              cur_sel,
    output logic              frame_done,
    output logic              err_sof,
    output logic [31:0]       drop_cnt
);
    // state | meaning
    // IDLE  | disabled, nothing accepted or driven
    // ARB   | pick an SOF source, flush stale non-SOF beats
    // PASS  | forward the granted source until its last line ends
    // GAP   | programmable idle spacing after a frame
    typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_PASS, ST_GAP} state_t;

    localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

    state_t            state, state_nxt;
    logic              last_sel;
    logic              first_beat;
    logic [ROW_W-1:0]  row_cnt, gap_cnt, rows_lat, gap_lat, row_eff;

    logic              cand0, cand1, flush0, flush1, win, win_sel;
    logic [DATA_W-1:0] sel_data;
    logic              sel_valid, sel_user, sel_last;
    logic              hs, mid_sof, frame_end;
    logic [1:0]        drop_inc;
    logic [32:0]       drop_sum;

    always_comb begin
        cand0     = s0_axis_tvalid & s0_axis_tuser;
        cand1     = s1_axis_tvalid & s1_axis_tuser;
        flush0    = (state == ST_ARB) & s0_axis_tvalid & ~s0_axis_tuser;
        flush1    = (state == ST_ARB) & s1_axis_tvalid & ~s1_axis_tuser;
        win       = (state == ST_ARB) & cfg_en & (cand0 | cand1);
        win_sel   = (cand0 & cand1) ? ~last_sel : cand1;

        sel_data  = cur_sel ? s1_axis_tdata  : s0_axis_tdata;
        sel_valid = cur_sel ? s1_axis_tvalid : s0_axis_tvalid;
        sel_user  = cur_sel ? s1_axis_tuser  : s0_axis_tuser;
        sel_last  = cur_sel ? s1_axis_tlast  : s0_axis_tlast;

        hs        = (state == ST_PASS) & sel_valid & m_axis_tready;
        mid_sof   = hs & sel_user & ~first_beat;
        // A mid-frame SOF restarts line counting on the beat that carries it
        row_eff   = mid_sof ? '0 : row_cnt;
        frame_end = hs & sel_last & (row_eff == rows_lat - ROW_ONE);

        drop_inc  = {1'b0, flush0} + {1'b0, flush1};
        drop_sum  = {1'b0, drop_cnt} + {31'b0, drop_inc};
    end

    always_comb begin
        state_nxt      = state;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tuser   = 1'b0;
        m_axis_tlast   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_en) state_nxt = ST_ARB;
            end
            ST_ARB: begin
                s0_axis_tready = flush0;
                s1_axis_tready = flush1;
                if (!cfg_en)  state_nxt = ST_IDLE;
                else if (win) state_nxt = ST_PASS;
            end
            ST_PASS: begin
                m_axis_tdata  = sel_data;
                m_axis_tvalid = sel_valid;
                m_axis_tuser  = sel_user;
                m_axis_tlast  = sel_last;
                if (cur_sel) s1_axis_tready = m_axis_tready;
                else         s0_axis_tready = m_axis_tready;
                if (frame_end) state_nxt = (gap_lat == '0) ? ST_ARB : ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == gap_lat - ROW_ONE) state_nxt = cfg_en ? ST_ARB : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state      <= ST_IDLE;
            cur_sel    <= 1'b0;
            last_sel   <= 1'b1;
            first_beat <= 1'b0;
            row_cnt    <= '0;
            gap_cnt    <= '0;
            rows_lat   <= ROW_ONE;
            gap_lat    <= '0;
            drop_cnt   <= '0;
            frame_done <= 1'b0;
            err_sof    <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= frame_end;
            err_sof    <= mid_sof;
            if (drop_inc != 2'd0) drop_cnt <= drop_sum[32] ? '1 : drop_sum[31:0];
            if (win) begin
                cur_sel    <= win_sel;
                rows_lat   <= (cfg_rows == '0) ? ROW_ONE : cfg_rows;
                gap_lat    <= cfg_gap;
                row_cnt    <= '0;
                first_beat <= 1'b1;
            end
            if (hs) begin
                first_beat <= 1'b0;
                if (frame_end) begin
                    last_sel <= cur_sel;
                    row_cnt  <= '0;
                end else if (sel_last) begin
                    row_cnt  <= row_eff + ROW_ONE;
                end else if (mid_sof) begin
                    row_cnt  <= '0;
                end
            end
            if (frame_end)             gap_cnt <= '0;
            else if (state == ST_GAP)  gap_cnt <= gap_cnt + ROW_ONE;
        end
    end
endmodule
